// File: rtl/mem_stage_hs_pkg.sv
// Shared types and constants for the RV32I memory stage: funct3 codes, FSM states,
// exception codes and the MEM/WB register layout.
package mem_stage_hs_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE, WAIT} mem_state_e;

    typedef enum logic [1:0] {
        EXC_NONE           = 2'b00,
        EXC_LOAD_MISALIGN  = 2'b01,
        EXC_STORE_MISALIGN = 2'b10,
        EXC_TIMEOUT        = 2'b11
    } exc_e;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  write_back;
        logic [31:0] mem_data;
        logic [31:0] alu_out;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [1:0]  exc;
    } wb_t;

    // Size comes from funct3[1:0]; the illegal codes 011/11x fall through to word.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        unique case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_lo[0];
            default: misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_hs_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface mem_stage_hs_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage_hs_lsu_align.sv
// Lane steering for the memory stage: byte enables and replicated store data on the way out,
// lane selection with sign/zero extension on the way back.
module mem_stage_hs_lsu_align
    import mem_stage_hs_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_addr_lo,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        unique case (st_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << st_addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {st_addr_lo[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half = rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        ld_data = rdata;
        unique case (ld_funct3[1:0])
            2'b00:   ld_data = ld_funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = ld_funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// RV32I memory stage: sized loads/stores over a req/ack bus with watchdog, misalignment
// detection and the MEM/WB pipeline register.
module mem_stage_hs
    import mem_stage_hs_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_write_m,
    input  logic [1:0]      write_back_m,
    input  logic            load_m,
    input  logic            store_m,
    input  logic [2:0]      funct3_m,
    input  logic            flush_m,
    input  logic [XLEN-1:0] alu_out_m,
    input  logic [XLEN-1:0] op_b_m,
    input  logic [XLEN-1:0] pc4_m,
    input  logic [4:0]      rd_m,
    mem_stage_hs_if.master  mem,
    output logic            stall_m,
    output logic            reg_write_w,
    output logic [1:0]      write_back_w,
    output logic [XLEN-1:0] mem_data_w,
    output logic [XLEN-1:0] alu_out_w,
    output logic [XLEN-1:0] pc4_w,
    output logic [4:0]      rd_w,
    output logic [1:0]      exc_w,
    output logic [4:0]      rd_m_addr,
    output logic [XLEN-1:0] rd_m_data,
    output logic            rd_m_write_signal
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("mem_stage_hs: XLEN must be 32");
    end
    if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cnt_chk
        $error("mem_stage_hs: CNT_W too narrow for TIMEOUT");
    end

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             flush_pend_q, flush_pend_d;
    logic [1:0]       addr_lo_q;
    logic [2:0]       funct3_q;
    wb_t              wb_q, wb_d;

    logic            access, misal, timeout_hit, req, done, tmo, killed;
    logic [1:0]      ld_addr_lo;
    logic [2:0]      ld_funct3;
    logic [XLEN-1:0] ld_data;

    assign access      = (load_m | store_m) & ~flush_m;
    assign misal       = misaligned(funct3_m, alu_out_m[1:0]);
    assign timeout_hit = (TIMEOUT != 0) && (wdog_q == CNT_W'(TIMEOUT));

    // Completion in WAIT uses the size/lane latched at issue.
    assign ld_addr_lo = (state_q == WAIT) ? addr_lo_q : alu_out_m[1:0];
    assign ld_funct3  = (state_q == WAIT) ? funct3_q : funct3_m;

    mem_stage_hs_lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .st_funct3 (funct3_m),
        .st_addr_lo(alu_out_m[1:0]),
        .st_data   (op_b_m),
        .be        (mem.mem_be),
        .wdata     (mem.mem_wdata),
        .ld_funct3 (ld_funct3),
        .ld_addr_lo(ld_addr_lo),
        .rdata     (mem.mem_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        flush_pend_d = flush_pend_q;
        req          = 1'b0;
        stall_m      = 1'b0;
        done         = 1'b0;
        tmo          = 1'b0;
        killed       = flush_m;
        unique case (state_q)
            IDLE: begin
                if (access && !misal) begin
                    req = 1'b1;
                    if (mem.mem_ack) begin
                        done = 1'b1;
                    end else begin
                        stall_m = 1'b1;
                        state_d = WAIT;
                        wdog_d  = '0;
                    end
                end
            end
            WAIT: begin
                killed = flush_pend_q | flush_m;
                if (timeout_hit) begin
                    tmo          = 1'b1;
                    state_d      = IDLE;
                    wdog_d       = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    // Stores are never aborted by a flush; the flush only kills the WB result.
                    req = 1'b1;
                    if (mem.mem_ack) begin
                        done         = 1'b1;
                        state_d      = IDLE;
                        wdog_d       = '0;
                        flush_pend_d = 1'b0;
                    end else begin
                        stall_m = 1'b1;
                        wdog_d  = wdog_q + CNT_W'(1);
                        if (flush_m) flush_pend_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_d = '0;
        if (!stall_m && !killed) begin
            wb_d.write_back = write_back_m;
            wb_d.alu_out    = alu_out_m;
            wb_d.pc4        = pc4_m;
            wb_d.rd         = rd_m;
            if (tmo) begin
                wb_d.exc = EXC_TIMEOUT;
            end else if (access && misal) begin
                wb_d.exc = load_m ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
            end else begin
                wb_d.reg_write = reg_write_m;
                if (done && load_m) wb_d.mem_data = ld_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wdog_q       <= '0;
            flush_pend_q <= 1'b0;
            addr_lo_q    <= '0;
            funct3_q     <= '0;
            wb_q         <= '0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            flush_pend_q <= flush_pend_d;
            if (state_q == IDLE) begin
                addr_lo_q <= alu_out_m[1:0];
                funct3_q  <= funct3_m;
            end
            wb_q <= wb_d;
        end
    end

    assign mem.mem_req  = req & ~rst;
    assign mem.mem_we   = req & ~rst & store_m;
    assign mem.mem_addr = {alu_out_m[XLEN-1:2], 2'b00};

    assign reg_write_w  = wb_q.reg_write;
    assign write_back_w = wb_q.write_back;
    assign mem_data_w   = wb_q.mem_data;
    assign alu_out_w    = wb_q.alu_out;
    assign pc4_w        = wb_q.pc4;
    assign rd_w         = wb_q.rd;
    assign exc_w        = wb_q.exc;

    assign rd_m_addr         = rd_m;
    assign rd_m_data         = alu_out_m;
    assign rd_m_write_signal = reg_write_m & ~flush_m;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed cases plus randomized instructions checked
// against a transaction-level model of the access, its latency and its WB result.
module tb_mem_stage_hs;
    import mem_stage_hs_pkg::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_m, load_m, store_m, flush_m;
    logic [1:0]  write_back_m;
    logic [2:0]  funct3_m;
    logic [31:0] alu_out_m, op_b_m, pc4_m;
    logic [4:0]  rd_m;
    logic        stall_m, reg_write_w, rd_m_write_signal;
    logic [1:0]  write_back_w, exc_w;
    logic [31:0] mem_data_w, alu_out_w, pc4_w, rd_m_data;
    logic [4:0]  rd_w, rd_m_addr;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mem_stage_hs_if #(.XLEN(32)) bus ();

    mem_stage_hs #(
        .XLEN   (32),
        .TIMEOUT(T),
        .CNT_W  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .reg_write_m      (reg_write_m),
        .write_back_m     (write_back_m),
        .load_m           (load_m),
        .store_m          (store_m),
        .funct3_m         (funct3_m),
        .flush_m          (flush_m),
        .alu_out_m        (alu_out_m),
        .op_b_m           (op_b_m),
        .pc4_m            (pc4_m),
        .rd_m             (rd_m),
        .mem              (bus),
        .stall_m          (stall_m),
        .reg_write_w      (reg_write_w),
        .write_back_w     (write_back_w),
        .mem_data_w       (mem_data_w),
        .alu_out_w        (alu_out_w),
        .pc4_w            (pc4_w),
        .rd_w             (rd_w),
        .exc_w            (exc_w),
        .rd_m_addr        (rd_m_addr),
        .rd_m_data        (rd_m_data),
        .rd_m_write_signal(rd_m_write_signal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int access_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        int          sz;
        sz = access_size(f3);
        if (sz == 1) begin
            v = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = access_size(f3);
        if (sz == 1) return 32'd1 << addr[1:0];
        if (sz == 2) return 32'd3 << (addr[1:0] & 2'b10);
        return 32'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int sz;
        sz = access_size(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // One instruction through MEM. lat: cycle (from issue) at which ack rises and stays high;
    // fl: cycle at which flush_m pulses for one cycle (-1 = never).
    task automatic run(input logic ld, input logic st, input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] opb,
                       input logic [31:0] rdata, input int lat, input int fl);
        logic        acc, mis, tmo, killed, exp_req;
        int          done_c;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [1:0]  wb;
        pc4    = $urandom;
        rd     = 5'($urandom);
        wb     = 2'($urandom);
        acc    = (ld | st) && (fl != 0);
        mis    = acc && ((int'(addr[1:0]) % access_size(f3)) != 0);
        tmo    = acc && !mis && (lat > T);
        done_c = (!acc || mis) ? 0 : (tmo ? T + 1 : lat);
        killed = (fl >= 0) && (fl <= done_c);

        @(negedge clk);
        load_m       = ld;
        store_m      = st;
        reg_write_m  = rw;
        funct3_m     = f3;
        alu_out_m    = addr;
        op_b_m       = opb;
        pc4_m        = pc4;
        rd_m         = rd;
        write_back_m = wb;
        bus.mem_rdata = rdata;
        for (int c = 0; c <= done_c; c++) begin
            if (c > 0) @(negedge clk);
            flush_m     = (c == fl);
            bus.mem_ack = acc && !mis && (c >= lat);
            #1;
            exp_req = acc && !mis && !(tmo && c == done_c);
            check("mem_req", 32'(bus.mem_req), 32'(exp_req));
            check("stall_m", 32'(stall_m), 32'(c < done_c));
            if (c == 0) begin
                check("rd_m_addr", 32'(rd_m_addr), 32'(rd));
                check("rd_m_data", rd_m_data, addr);
                check("rd_m_write", 32'(rd_m_write_signal), 32'(rw && fl != 0));
                if (exp_req) begin
                    check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                    check("mem_we", 32'(bus.mem_we), 32'(st));
                    check("mem_be", 32'(bus.mem_be), ref_be(f3, addr));
                    if (st) check("mem_wdata", bus.mem_wdata, ref_wdata(f3, opb));
                end
            end
            @(posedge clk);
            #1;
            if (c < done_c) begin
                check("bubble_rw", 32'(reg_write_w), 32'd0);
                check("bubble_exc", 32'(exc_w), 32'd0);
            end
        end
        if (killed) begin
            check("flush_rw", 32'(reg_write_w), 32'd0);
            check("flush_exc", 32'(exc_w), 32'd0);
        end else if (tmo) begin
            check("tmo_rw", 32'(reg_write_w), 32'd0);
            check("tmo_exc", 32'(exc_w), 32'd3);
        end else if (mis) begin
            check("mis_rw", 32'(reg_write_w), 32'd0);
            check("mis_exc", 32'(exc_w), ld ? 32'd1 : 32'd2);
        end else begin
            check("wb_rw", 32'(reg_write_w), 32'(rw));
            check("wb_exc", 32'(exc_w), 32'd0);
            check("wb_rd", 32'(rd_w), 32'(rd));
            check("wb_sel", 32'(write_back_w), 32'(wb));
            check("wb_alu", alu_out_w, addr);
            check("wb_pc4", pc4_w, pc4);
            if (ld) check("wb_mem_data", mem_data_w, ref_load(f3, addr, rdata));
        end
        @(negedge clk);
        flush_m     = 1'b0;
        bus.mem_ack = 1'b0;
        load_m      = 1'b0;
        store_m     = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind, lat, fl;
        rst = 1'b1;
        {reg_write_m, load_m, store_m, flush_m} = '0;
        write_back_m = '0;
        funct3_m     = '0;
        alu_out_m    = '0;
        op_b_m       = '0;
        pc4_m        = '0;
        rd_m         = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
        #1;
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_rw", 32'(reg_write_w), 32'd0);
        check("rst_exc", 32'(exc_w), 32'd0);
        check("rst_pc4", pc4_w, 32'd0);
        check("rst_data", mem_data_w, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 1'b1, 1'b0, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, -1);
        run(1'b1, 1'b0, 1'b1, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, -1);
        run(1'b0, 1'b1, 1'b0, F3_B, 32'h103, 32'h0000_00A5, 32'h0, 0, -1);
        run(1'b1, 1'b0, 1'b1, F3_B, 32'h103, 32'h0, 32'h8000_0000, 0, -1);
        run(1'b1, 1'b0, 1'b1, F3_BU, 32'h103, 32'h0, 32'h8000_0000, 0, -1);
        run(1'b1, 1'b0, 1'b1, F3_H, 32'h102, 32'h0, 32'h8001_1234, 3, -1);
        run(1'b1, 1'b0, 1'b1, F3_W, 32'h101, 32'h0, 32'h0, 0, -1);
        run(1'b0, 1'b1, 1'b0, F3_H, 32'h003, 32'h1234, 32'h0, 0, -1);
        run(1'b1, 1'b0, 1'b1, F3_W, 32'h200, 32'h0, 32'h5555_AAAA, 99, -1);
        run(1'b1, 1'b0, 1'b1, F3_W, 32'h204, 32'h0, 32'h5555_AAAA, T + 1, -1);
        run(1'b0, 1'b1, 1'b0, F3_W, 32'h300, 32'hCAFE_F00D, 32'h0, 3, 2);
        run(1'b1, 1'b0, 1'b1, F3_HU, 32'h306, 32'h0, 32'hBEEF_0000, 1, -1);

        // Reset in the middle of a pending store.
        @(negedge clk);
        store_m   = 1'b1;
        funct3_m  = F3_W;
        alu_out_m = 32'h400;
        op_b_m    = 32'h1111_2222;
        repeat (2) @(negedge clk);
        #1;
        check("wait_req", 32'(bus.mem_req), 32'd1);
        check("wait_stall", 32'(stall_m), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(bus.mem_req), 32'd0);
        check("midrst_rw", 32'(reg_write_w), 32'd0);
        check("midrst_exc", 32'(exc_w), 32'd0);
        check("midrst_alu", alu_out_w, 32'd0);
        store_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run(1'b1, 1'b0, 1'b1, F3_W, 32'h404, 32'h0, 32'h0BAD_F00D, 0, -1);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 4);
            f3   = 3'($urandom);
            a    = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            lat  = ($urandom_range(0, 7) == 0) ? $urandom_range(T, T + 3) : $urandom_range(0, 3);
            fl   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
            if (kind <= 1)
                run(1'b1, 1'b0, 1'($urandom), f3, a, $urandom, $urandom, lat, fl);
            else if (kind <= 3)
                run(1'b0, 1'b1, 1'b0, f3, a, $urandom, $urandom, lat, fl);
            else
                run(1'b0, 1'b0, 1'($urandom), f3, a, $urandom, $urandom, lat, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Next-generation RV32I memory stage that replaces the fixed single-cycle, word-only memory access.
- Supports LB/LH/LW/LBU/LHU/SB/SH/SW with byte enables, lane alignment and sign/zero extension.
- Talks to an external data memory over a req/ack handshake of arbitrary latency, stalling the pipeline until ack.
- Detects misaligned accesses and bus timeouts, and owns the MEM/WB pipeline register.
- Sits between the execute stage and write-back; forwards `rd`, its data and its write-enable to the hazard unit.

Parameters:
- `XLEN`, 32: datapath width. Only 32 is legal; elaborate-time assertion otherwise.
- `TIMEOUT`, 255: maximum cycles spent waiting for `mem_ack` before an abort. 0 disables the watchdog.
- `CNT_W`, 8: watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `reg_write_m` in 1: instruction writes rd.
- `write_back_m` in 2: WB mux select, passed through.
- `load_m` in 1: load instruction.
- `store_m` in 1: store instruction.
- `funct3_m` in 3: access size/sign.
- `flush_m` in 1: kill the instruction in MEM.
- `alu_out_m` in XLEN: address / ALU result.
- `op_b_m` in XLEN: store data.
- `pc4_m` in XLEN: PC+4.
- `rd_m` in 5: destination register.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write request.
- `mem_addr` out XLEN: word-aligned address ({alu_out_m[31:2],2'b00}).
- `mem_be` out 4: byte enables.
- `mem_wdata` out XLEN: lane-replicated store data.
- `mem_rdata` in XLEN: read word.
- `mem_ack` in 1: request accepted/completed.
- `stall_m` out 1: hold IF..EX and MEM inputs.
- `reg_write_w` out 1: registered to WB.
- `write_back_w` out 2: registered to WB.
- `mem_data_w` out XLEN: registered to WB.
- `alu_out_w` out XLEN: registered to WB.
- `pc4_w` out XLEN: registered to WB.
- `rd_w` out 5: registered to WB.
- `exc_w` out 2: 00 none, 01 load-misaligned, 10 store-misaligned, 11 bus timeout.
- `rd_m_addr` out 5: combinational, = `rd_m`.
- `rd_m_data` out XLEN: combinational, = `alu_out_m`.
- `rd_m_write_signal` out 1: combinational, = `reg_write_m & ~flush_m`.

Behaviour:
- Reset (async, `rst`=1): FSM to IDLE, watchdog=0, flush_pend=0. All `_w` outputs 0. `mem_req`=0.
- Access definitions:
  - access = (load_m|store_m) & ~flush_m.
  - misaligned: funct3[1:0]=01 with addr[0]=1, or funct3[1:0]=10 with addr[1:0]≠0. Illegal funct3 (011, 11x) is treated as W.
- Byte enables and store data:
  - SB: be = 0001<<addr[1:0], wdata = {4{b}}.
  - SH: be = 0011<<{addr[1],1'b0}, wdata = {2{h}}.
  - SW: be = 1111.
  - For loads, `mem_be` carries the same lanes and `mem_we`=0.
- Load extraction: select lane by addr[1:0]. Sign-extend for funct3 000/001, zero-extend for 100/101. Uses the registered addr/funct3 of the instruction being completed.
- FSM states:
  - IDLE:
    - access & aligned → `mem_req`=1 combinationally. If `mem_ack` arrives the same cycle: complete, stay IDLE, `stall_m`=0. Otherwise `stall_m`=1 and go to WAIT.
    - access & misaligned → no request, no stall. WB receives `reg_write_w`=0 and `exc_w`=01 (load) or 10 (store).
  - WAIT:
    - `mem_req` held high; inputs are stable because `stall_m`=1. Watchdog increments each cycle.
    - `mem_ack` → IDLE, capture result, `stall_m`=0.
    - Watchdog == TIMEOUT (with TIMEOUT≠0) → drop `mem_req`, go to IDLE. WB receives `reg_write_w`=0 and `exc_w`=11. A late ack is ignored.
- Flush:
  - `flush_m` in IDLE → bubble, no request.
  - `flush_m` while in WAIT → set flush_pend. The transaction completes (stores are never aborted); on ack a bubble is written to WB (`reg_write_w`=0, `exc_w`=0). flush_pend clears on leaving WAIT.
- MEM/WB register:
  - Captures when `stall_m`=0.
  - While `stall_m`=1 it loads a bubble (`reg_write_w`=0, `exc_w`=0, other fields don't-care but zeroed), so WB never retires an instruction twice.
- Latency: zero-wait ack → result at `_w` one cycle after issue. N-cycle ack → N+1.
- Reset asserted in WAIT aborts immediately; the memory side must tolerate the dropped request.

Decomposition:
- `mem_pkg`:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - `mem_state_e` {IDLE, WAIT}.
  - `exc_e` codes.
- Sub-module `lsu_align` (combinational): generates be/wdata and extracts/extends load data. Instantiated once.

Test Plan:
1. SW addr 0x100 data 0xDEADBEEF, ack same cycle → mem_be=1111, stall_m never 1; LW 0x100 with rdata 0xDEADBEEF → mem_data_w=0xDEADBEEF next cycle.
2. SB addr 0x103 data 0x000000A5 → mem_be=1000, wdata=0xA5A5A5A5. LB 0x103 with rdata 0x80000000 → 0xFFFFFF80. LBU → 0x00000080.
3. LH addr 0x102, ack after 3 cycles, rdata 0x8001xxxx → stall_m=1 for 3 cycles, 3 bubbles at WB, then mem_data_w=0xFFFF8001 with reg_write_w=1.
4. LW addr 0x101 → mem_req=0, reg_write_w=0, exc_w=01. SH addr 0x003 → exc_w=10.
5. TIMEOUT=4, no ack → mem_req high 5 cycles then low, exc_w=11, stall_m released. Late ack ignored.
6. flush_m asserted during WAIT of SW, then ack → store completes (mem_req held to ack), WB gets bubble. `rst` pulsed mid-WAIT → all outputs 0, FSM IDLE.
